// File: rtl/fetch_hazard_ctrl_pkg.sv
// fetch_hazard_ctrl_pkg: shared pipeline constants, state encoding and hazard helper
package fetch_hazard_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;
  function automatic logic load_use(input logic mem_read, input logic [4:0] ex_rt,
                                    input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    return mem_read && ex_rt != REG_ZERO && (ex_rt == rs || (uses_rt && ex_rt == rt));
  endfunction
endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// fetch_hazard_ctrl_if: hazard inputs and pipeline-latch controls between fetch/decode and the controller
interface fetch_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic id_uses_rt;
  logic ex_mem_read;
  logic [4:0] ex_rt;
  logic branch_taken;
  logic imem_ready;
  logic dmem_busy;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_bubble;
  modport master (output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, imem_ready, dmem_busy,
                  input pc_write, ifid_write, ifid_flush, idex_write, idex_bubble);
  modport slave (input id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, imem_ready, dmem_busy,
                 output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble);
endinterface

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int CNT_W = 16) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: PC/IF-ID/ID-EX sequencing with load-use, branch flush and dmem freeze handling
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int EXTRA_FLUSH = 0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  fetch_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state, state_n;
  logic [2:0] flush_left, flush_left_n;
  logic lu;
  assign lu = load_use(hz.ex_mem_read, hz.ex_rt, hz.id_rs, hz.id_rt, hz.id_uses_rt);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_RUN;
      flush_left <= 3'd0;
    end else begin
      state <= state_n;
      flush_left <= flush_left_n;
    end
  always_comb begin
    state_n = state;
    flush_left_n = flush_left;
    hz.pc_write = 1'b1;
    hz.ifid_write = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_write = 1'b1;
    hz.idex_bubble = 1'b0;
    if (reset) begin
      hz.pc_write = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (hz.dmem_busy) begin
      hz.pc_write = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_write = 1'b0;
    end else if (hz.branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_bubble = 1'b1;
      state_n = EXTRA_FLUSH > 0 ? ST_FLUSH : ST_RUN;
      flush_left_n = 3'(EXTRA_FLUSH);
    end else if (state == ST_FLUSH) begin
      hz.pc_write = hz.imem_ready;
      hz.ifid_flush = 1'b1;
      flush_left_n = hz.imem_ready ? flush_left - 3'd1 : flush_left;
      state_n = hz.imem_ready && flush_left == 3'd1 ? ST_RUN : ST_FLUSH;
    end else if (lu) begin
      // the ID instruction is held even if I-mem misses, so no flush here
      hz.pc_write = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_bubble = 1'b1;
    end else if (!hz.imem_ready) begin
      hz.pc_write = 1'b0;
      hz.ifid_flush = 1'b1;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(!hz.pc_write), .clear(1'b0), .q(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(hz.ifid_flush), .clear(1'b0), .q(flush_cnt)
  );
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl: directed and random checks against a priority-rule reference model
module tb_fetch_hazard_ctrl;
  localparam int EF = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [CW-1:0] stall_cnt, flush_cnt;
  fetch_hazard_ctrl_if hz ();
  fetch_hazard_ctrl #(.EXTRA_FLUSH(EF), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hz(hz), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int m_left = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit e_pc, e_ifw, e_fl, e_idw, e_bub;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_out();
    bit lu;
    lu = hz.ex_mem_read && hz.ex_rt != 0 &&
         (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
    {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b11010;
    if (hz.dmem_busy) {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00000;
    else if (hz.branch_taken) {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b11111;
    else if (m_left > 0) {e_pc, e_ifw, e_fl, e_idw, e_bub} = {hz.imem_ready, 4'b1110};
    else if (lu) {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00011;
    else if (!hz.imem_ready) {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b01110;
  endtask
  task automatic set_in(input bit mr, input int ert, input int rs, input int rt, input bit urt,
                        input bit br, input bit im, input bit db);
    hz.ex_mem_read = mr; hz.ex_rt = 5'(ert); hz.id_rs = 5'(rs); hz.id_rt = 5'(rt);
    hz.id_uses_rt = urt; hz.branch_taken = br; hz.imem_ready = im; hz.dmem_busy = db;
  endtask
  task automatic cyc();
    @(negedge clk);
    model_out();
    chk("pc_write", hz.pc_write, e_pc);
    chk("ifid_write", hz.ifid_write, e_ifw);
    chk("ifid_flush", hz.ifid_flush, e_fl);
    chk("idex_write", hz.idex_write, e_idw);
    chk("idex_bubble", hz.idex_bubble, e_bub);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    @(posedge clk);
    if (!hz.dmem_busy) begin
      if (hz.branch_taken) m_left = EF;
      else if (m_left > 0 && hz.imem_ready) m_left--;
    end
    if (!e_pc && m_stall < CMAX) m_stall++;
    if (e_fl && m_flush < CMAX) m_flush++;
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pc_write", hz.pc_write, 0);
    chk("rst_ifid_write", hz.ifid_write, 0);
    chk("rst_ifid_flush", hz.ifid_flush, 1);
    chk("rst_idex_write", hz.idex_write, 1);
    chk("rst_idex_bubble", hz.idex_bubble, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    #2;
    reset = 1'b0;
    m_left = 0; m_stall = 0; m_flush = 0;
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    cyc();
    cyc();
    do_reset();
    cyc();
    chk("idle_pc_write", hz.pc_write, 1);
    set_in(1, 5, 5, 0, 0, 0, 1, 0);
    cyc();
    set_in(0, 5, 5, 0, 0, 0, 1, 0);
    cyc();
    chk("lu_stall_cnt", stall_cnt, 1);
    set_in(1, 0, 0, 0, 1, 0, 1, 0);
    cyc();
    set_in(1, 5, 3, 5, 0, 0, 1, 0);
    cyc();
    chk("no_lu_stall_cnt", stall_cnt, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    cyc();
    hz.branch_taken = 1'b0;
    repeat (3) cyc();
    chk("br_flush_cnt", flush_cnt, 3);
    hz.branch_taken = 1'b1;
    cyc();
    hz.branch_taken = 1'b0;
    hz.imem_ready = 1'b0;
    cyc();
    hz.imem_ready = 1'b1;
    repeat (3) cyc();
    chk("br_miss_flush_cnt", flush_cnt, 7);
    do_reset();
    set_in(1, 7, 7, 0, 0, 1, 1, 1);
    repeat (4) cyc();
    chk("frz_stall_cnt", stall_cnt, 4);
    chk("frz_flush_cnt", flush_cnt, 0);
    hz.dmem_busy = 1'b0;
    #1;
    chk("frz_release_flush", hz.ifid_flush, 1);
    chk("frz_release_pc", hz.pc_write, 1);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) cyc();
    set_in(1, 9, 2, 9, 1, 0, 0, 0);
    cyc();
    hz.ex_mem_read = 1'b0;
    #1;
    chk("miss_after_lu_flush", hz.ifid_flush, 1);
    cyc();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) cyc();
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_flush_cnt", flush_cnt, 15);
    for (int i = 0; i < 600; i++) begin
      bit db, br;
      db = ($urandom_range(0, 5) == 0);
      br = hz.dmem_busy ? hz.branch_taken : ($urandom_range(0, 7) == 0);
      set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), br, $urandom_range(0, 3) != 0, db);
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
